// File: rtl/scan_beta_update.sv
// SCAN beta update stage: two-stage pipeline that turns left/right child betas plus parent
// LLRs into the two parent betas and formats them as one write beat for the beta RAM.
module scan_beta_update #(
    parameter int unsigned P = 64,
    parameter int unsigned Q = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_last,
    input  logic [4:0]         in_layer,
    input  logic [8:0]         in_addr,
    input  logic [5:0]         in_cnt,
    input  logic [P*Q-1:0]     beta_l,
    input  logic [P*Q-1:0]     beta_r,
    input  logic [P*Q-1:0]     llr_u,
    input  logic [P*Q-1:0]     llr_d,
    input  logic               hold,
    output logic [2*P*Q-1:0]   b_out,
    output logic               w_en,
    output logic [4:0]         layer_w,
    output logic [8:0]         w_address,
    output logic [5:0]         cnta,
    output logic               done
);

    localparam int unsigned W  = P * Q;
    localparam int unsigned LW = 5;
    localparam int unsigned AW = 9;
    localparam int unsigned CW = 6;
    localparam int unsigned NW = 9;

    localparam logic [Q-1:0]        C_MAX    = {1'b0, {(Q-1){1'b1}}};
    localparam logic [Q-1:0]        C_MIN    = {1'b1, {(Q-2){1'b0}}, 1'b1};
    localparam logic [Q-1:0]        C_NEG    = {1'b1, {(Q-1){1'b0}}};
    localparam logic signed [Q:0]   SUM_MAX  = {2'b00, {(Q-1){1'b1}}};
    localparam logic signed [Q:0]   SUM_MIN  = {2'b11, {(Q-2){1'b0}}, 1'b1};

    // Magnitude with the most negative code folded onto the largest positive value.
    function automatic logic [Q-1:0] f_abs(input logic [Q-1:0] a);
        if (!a[Q-1])    return a;
        if (a == C_NEG) return C_MAX;
        return -a;
    endfunction

    // Min-sum box-plus: sign product times the smaller magnitude.
    function automatic logic [Q-1:0] f_minsum(input logic [Q-1:0] a, input logic [Q-1:0] b);
        logic [Q-1:0] ma;
        logic [Q-1:0] mb;
        logic [Q-1:0] m;
        ma = f_abs(a);
        mb = f_abs(b);
        m  = (ma < mb) ? ma : mb;
        return (a[Q-1] ^ b[Q-1]) ? -m : m;
    endfunction

    // Symmetric saturating add.
    function automatic logic [Q-1:0] f_sat(input logic [Q-1:0] a, input logic [Q-1:0] b);
        logic signed [Q:0] s;
        s = $signed({a[Q-1], a}) + $signed({b[Q-1], b});
        if (s > SUM_MAX) return C_MAX;
        if (s < SUM_MIN) return C_MIN;
        return s[Q-1:0];
    endfunction

    logic            r_v1;
    logic            r_last1;
    logic [LW-1:0]   r_layer1;
    logic [AW-1:0]   r_addr1;
    logic [CW-1:0]   r_cnt1;
    logic [W-1:0]    r_bl1;
    logic [W-1:0]    r_br1;
    logic [W-1:0]    r_g1;
    logic [W-1:0]    r_h1;

    logic [2*W-1:0]  r_b_out;
    logic            r_w_en;
    logic [LW-1:0]   r_layer_w;
    logic [AW-1:0]   r_w_address;
    logic [CW-1:0]   r_cnta;
    logic            r_done;

    logic [W-1:0]    w_g;
    logic [W-1:0]    w_h;
    logic [2*W-1:0]  w_b_nxt;
    logic            w_layer_ok1;
    logic [NW-1:0]   w_n;

    assign in_ready    = ~hold;
    assign w_layer_ok1 = (r_layer1 != '0) && (r_layer1 <= LW'(8));
    assign w_n         = NW'(1) << (r_layer1 - LW'(1));

    for (genvar k = 0; k < P; k++) begin : g_lane
        logic w_on;
        assign w_g[k*Q +: Q] = f_sat(beta_r[k*Q +: Q], llr_d[k*Q +: Q]);
        assign w_h[k*Q +: Q] = f_minsum(beta_l[k*Q +: Q], llr_u[k*Q +: Q]);
        // Lanes beyond the node width of the target layer, and bubbles, write zero.
        assign w_on = r_v1 && w_layer_ok1 && (32'(k) < 32'(w_n));
        assign w_b_nxt[k*Q +: Q]     = w_on ? f_minsum(r_bl1[k*Q +: Q], r_g1[k*Q +: Q]) : '0;
        assign w_b_nxt[W + k*Q +: Q] = w_on ? f_sat(r_br1[k*Q +: Q], r_h1[k*Q +: Q])    : '0;
    end

    // Both stages advance together; hold freezes everything, reset wins over hold.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_v1        <= 1'b0;
            r_last1     <= 1'b0;
            r_layer1    <= '0;
            r_addr1     <= '0;
            r_cnt1      <= '0;
            r_bl1       <= '0;
            r_br1       <= '0;
            r_g1        <= '0;
            r_h1        <= '0;
            r_b_out     <= '0;
            r_w_en      <= 1'b0;
            r_layer_w   <= '0;
            r_w_address <= '0;
            r_cnta      <= '0;
            r_done      <= 1'b0;
        end else if (!hold) begin
            r_v1        <= in_valid;
            r_last1     <= in_last;
            r_layer1    <= in_layer;
            r_addr1     <= in_addr;
            r_cnt1      <= in_cnt;
            r_bl1       <= beta_l;
            r_br1       <= beta_r;
            r_g1        <= w_g;
            r_h1        <= w_h;
            r_b_out     <= w_b_nxt;
            r_w_en      <= r_v1 & w_layer_ok1;
            r_layer_w   <= r_layer1;
            r_w_address <= r_addr1;
            r_cnta      <= r_cnt1;
            r_done      <= r_v1 & r_last1;
        end
    end

    assign b_out     = r_b_out;
    assign w_en      = r_w_en;
    assign layer_w   = r_layer_w;
    assign w_address = r_w_address;
    assign cnta      = r_cnta;
    assign done      = r_done;

endmodule

// File: tb/tb_scan_beta_update.sv
// Directed bench for scan_beta_update: hand-computed beats, saturation corners, lane masking,
// hold stalls and reset of in-flight beats.
module tb_scan_beta_update;

    localparam int unsigned P = 64;
    localparam int unsigned Q = 6;
    localparam int unsigned W = P * Q;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic            in_last;
    logic [4:0]      in_layer;
    logic [8:0]      in_addr;
    logic [5:0]      in_cnt;
    logic [W-1:0]    beta_l;
    logic [W-1:0]    beta_r;
    logic [W-1:0]    llr_u;
    logic [W-1:0]    llr_d;
    logic            hold;
    logic [2*W-1:0]  b_out;
    logic            w_en;
    logic [4:0]      layer_w;
    logic [8:0]      w_address;
    logic [5:0]      cnta;
    logic            done;

    int n_vec;
    int n_err;

    scan_beta_update #(.P(P), .Q(Q)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_layer(in_layer), .in_addr(in_addr), .in_cnt(in_cnt),
        .beta_l(beta_l), .beta_r(beta_r), .llr_u(llr_u), .llr_d(llr_d), .hold(hold),
        .b_out(b_out), .w_en(w_en), .layer_w(layer_w), .w_address(w_address),
        .cnta(cnta), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic l, input int layer, input int addr,
                         input int cnt, input int bl, input int br, input int lu, input int ld);
        in_valid = v;
        in_last  = l;
        in_layer = 5'(layer);
        in_addr  = 9'(addr);
        in_cnt   = 6'(cnt);
        for (int k = 0; k < P; k++) begin
            beta_l[k*Q +: Q] = Q'(bl);
            beta_r[k*Q +: Q] = Q'(br);
            llr_u[k*Q +: Q]  = Q'(lu);
            llr_d[k*Q +: Q]  = Q'(ld);
        end
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic logic [2*W-1:0] mk(input int up, input int dn, input int n);
        logic [2*W-1:0] v;
        v = '0;
        for (int k = 0; k < n; k++) begin
            v[k*Q +: Q]     = Q'(up);
            v[W + k*Q +: Q] = Q'(dn);
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int bi;
        int ci;
        logic ph;
        logic pw;
        logic [2*W-1:0] pb;

        n_vec = 0;
        n_err = 0;
        clk   = 1'b0;
        rst   = 1'b0;
        hold  = 1'b1;
        idle();

        // Reset with hold asserted: reset still clears, in_ready follows hold.
        tick();
        chk("rst_ready_hold", 2*W'(in_ready), '0);
        chk("rst_wen", 2*W'(w_en), '0);
        chk("rst_done", 2*W'(done), '0);
        chk("rst_bout", b_out, '0);
        hold = 1'b0;
        #1;
        chk("rst_ready", 2*W'(in_ready), 2*W'(1));
        tick();
        chk("rst_sideband", 2*W'({layer_w, w_address, cnta}), '0);
        rst = 1'b1;
        tick();

        // Basic beat, layer 8: up=5, dn=-8 on all lanes, two-cycle latency.
        drive(1'b1, 1'b1, 8, 17, 40, 5, -3, -7, 10);
        tick();
        chk("basic_not_yet", 2*W'(w_en), '0);
        idle();
        tick();
        chk("basic_wen", 2*W'(w_en), 2*W'(1));
        chk("basic_bout", b_out, mk(5, -8, 64));
        chk("basic_addr", 2*W'(w_address), 2*W'(17));
        chk("basic_cnt", 2*W'(cnta), 2*W'(40));
        chk("basic_layer", 2*W'(layer_w), 2*W'(8));
        chk("basic_done", 2*W'(done), 2*W'(1));
        tick();
        chk("bubble_wen", 2*W'(w_en), '0);
        chk("bubble_bout", b_out, '0);
        chk("bubble_done", 2*W'(done), '0);

        // Saturation, back to back at layer 7 (all 64 lanes).
        drive(1'b1, 1'b0, 7, 1, 1, 31, 30, 1, 20);
        tick();
        drive(1'b1, 1'b0, 7, 2, 1, -9, -31, 4, 0);
        tick();
        chk("satA_bout", b_out, mk(31, 31, 64));
        chk("satA_done", 2*W'(done), '0);
        idle();
        tick();
        chk("satB_bout", b_out, mk(9, -31, 64));
        chk("satB_addr", 2*W'(w_address), 2*W'(2));

        // -32 inputs fold to +31; layer 1 leaves only lane 0 active.
        drive(1'b1, 1'b0, 1, 3, 1, -32, 0, -32, 0);
        tick();
        idle();
        tick();
        chk("neg32_bout", b_out, mk(0, 31, 1));

        // Layer 0: no write, zero data, but done still pulses.
        drive(1'b1, 1'b1, 0, 5, 5, 5, -3, -7, 10);
        tick();
        idle();
        tick();
        chk("l0_wen", 2*W'(w_en), '0);
        chk("l0_bout", b_out, '0);
        chk("l0_done", 2*W'(done), 2*W'(1));

        // Layer 9: out of range, also suppressed.
        drive(1'b1, 1'b0, 9, 6, 5, 5, -3, -7, 10);
        tick();
        idle();
        tick();
        chk("l9_wen", 2*W'(w_en), '0);
        chk("l9_bout", b_out, '0);

        // Layer 3 job of 4 beats: lanes 0..3 valid, done on the last one only.
        for (int i = 0; i < 6; i++) begin
            if (i < 4) drive(1'b1, i == 3, 3, i, 4, 5, -3, -7, 10);
            else       idle();
            tick();
            if (i >= 1 && i <= 4) begin
                chk($sformatf("l3_wen_%0d", i - 1), 2*W'(w_en), 2*W'(1));
                chk($sformatf("l3_addr_%0d", i - 1), 2*W'(w_address), 2*W'(i - 1));
                chk($sformatf("l3_bout_%0d", i - 1), b_out, mk(5, -8, 4));
                chk($sformatf("l3_done_%0d", i - 1), 2*W'(done), 2*W'(i == 4));
            end
        end

        // Six beats with a 3-cycle hold: beat j gives up=j+1, dn=-(j+4).
        bi = 0;
        ci = 0;
        ph = 1'b0;
        pw = 1'b0;
        pb = '0;
        for (int c = 0; c < 30 && ci < 6; c++) begin
            hold = (c >= 3 && c <= 5);
            if (bi < 6) drive(1'b1, bi == 5, 8, 10 + bi, bi, bi + 1, -3, -7, 10);
            else        idle();
            #1;
            chk("hold_ready", 2*W'(in_ready), 2*W'(!hold));
            if (ph) begin
                chk("hold_frozen_bout", b_out, pb);
                chk("hold_frozen_wen", 2*W'(w_en), 2*W'(pw));
            end
            if (w_en && !hold) begin
                chk($sformatf("hold_addr_%0d", ci), 2*W'(w_address), 2*W'(10 + ci));
                chk($sformatf("hold_bout_%0d", ci), b_out, mk(ci + 1, -(ci + 4), 64));
                chk($sformatf("hold_done_%0d", ci), 2*W'(done), 2*W'(ci == 5));
                ci++;
            end
            pb = b_out;
            pw = w_en;
            ph = hold;
            if (!hold && bi < 6) bi++;
            tick();
        end
        hold = 1'b0;
        chk("hold_count", 2*W'(ci), 2*W'(6));

        // Reset with two beats in flight: both are discarded.
        idle();
        tick();
        tick();
        drive(1'b1, 1'b1, 8, 30, 1, 5, -3, -7, 10);
        tick();
        drive(1'b1, 1'b1, 8, 31, 1, 5, -3, -7, 10);
        rst = 1'b0;
        tick();
        chk("rstfl_wen", 2*W'(w_en), '0);
        chk("rstfl_done", 2*W'(done), '0);
        chk("rstfl_bout", b_out, '0);
        rst = 1'b1;
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rstfl_after_wen_%0d", i), 2*W'(w_en), '0);
            chk($sformatf("rstfl_after_done_%0d", i), 2*W'(done), '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
